// File: rtl/pingpong_buff_ctrl.sv
`default_nettype none
// pingpong_buff_ctrl: schedules two external 4-bit FIFOs as a ping-pong frame buffer.
// Optional early frame close (flush port) enabled by defining PINGPONG_FLUSH_EN.
module pingpong_buff_ctrl #(
    parameter int FRAME_LEN = 32,
    parameter int DEPTH     = 32,
    parameter int CW        = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       src_valid,
    output logic       src_ready,
    output logic [1:0] fifo_wr_en,
    output logic [1:0] fifo_rd_en,
    input  logic [1:0] fifo_full,
    input  logic [1:0] fifo_empty,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       out_sel,
    output logic       frame_done,
    output logic [1:0] bank_busy,
    output logic       err
`ifdef PINGPONG_FLUSH_EN
    ,
    input  logic       flush
`endif
);

    // A frame can never be longer than what one bank holds.
    localparam int              LEN    = (FRAME_LEN < DEPTH) ? FRAME_LEN : DEPTH;
    localparam logic [CW-1:0]   LEN_CW = CW'(LEN);
    localparam logic [CW-1:0]   LEN_M1 = CW'(LEN - 1);

    typedef enum logic [1:0] {FREE, FILLING, READY, DRAINING} bank_st_t;
    typedef enum logic       {IDLE, DRAIN} rd_st_t;

    bank_st_t        bank_st [2];
    bank_st_t        bank_nx [2];
    rd_st_t          rd_st;
    rd_st_t          rd_st_nx;
    logic            init_done;
    logic            wr_bank;
    logic            rd_next;
    logic [CW-1:0]   wr_cnt;
    logic [CW-1:0]   rd_cnt;
    logic [CW-1:0]   cur_len;
    logic            accept;
    logic            rd_fire;
    logic            wr_last;
    logic            close;
    logic            rd_last;
    logic            err_set;

`ifdef PINGPONG_FLUSH_EN
    logic [CW-1:0]   len [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len[0] <= LEN_CW;
            len[1] <= LEN_CW;
        end else if (close) begin
            len[wr_bank] <= wr_cnt + CW'(accept);
        end
    end
`endif

    always_comb begin
        src_ready  = init_done && (bank_st[wr_bank] == FREE || bank_st[wr_bank] == FILLING);
        accept     = src_valid && src_ready;
        fifo_wr_en = {wr_bank & accept, ~wr_bank & accept};
        rd_fire    = (rd_st == DRAIN) && out_ready;
        fifo_rd_en = {rd_next & rd_fire, ~rd_next & rd_fire};
        wr_last    = accept && (wr_cnt == LEN_M1);
`ifdef PINGPONG_FLUSH_EN
        close      = wr_last || (flush && (accept || wr_cnt != '0));
        cur_len    = len[rd_next];
`else
        close      = wr_last;
        cur_len    = LEN_CW;
`endif
        rd_last    = rd_fire && (rd_cnt == cur_len - CW'(1));
        err_set    = (|(fifo_full & fifo_wr_en)) || (|(fifo_empty & fifo_rd_en));

        bank_nx[0] = bank_st[0];
        bank_nx[1] = bank_st[1];
        rd_st_nx   = rd_st;
        if (accept && bank_st[wr_bank] == FREE)
            bank_nx[wr_bank] = FILLING;
        if (close)
            bank_nx[wr_bank] = READY;
        // Writer and reader never touch the same bank in one cycle: their state sets are disjoint.
        case (rd_st)
            IDLE: begin
                if (bank_st[rd_next] == READY) begin
                    rd_st_nx         = DRAIN;
                    bank_nx[rd_next] = DRAINING;
                end
            end
            DRAIN: begin
                if (rd_last) begin
                    rd_st_nx         = IDLE;
                    bank_nx[rd_next] = FREE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done  <= 1'b0;
            bank_st[0] <= FREE;
            bank_st[1] <= FREE;
            rd_st      <= IDLE;
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_next    <= 1'b0;
            rd_cnt     <= '0;
            out_valid  <= 1'b0;
            out_sel    <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            init_done  <= 1'b1;
            bank_st[0] <= bank_nx[0];
            bank_st[1] <= bank_nx[1];
            rd_st      <= rd_st_nx;
            if (close) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else if (accept) begin
                wr_cnt  <= wr_cnt + CW'(1);
            end
            if (rd_last) begin
                rd_cnt  <= '0;
                rd_next <= ~rd_next;
            end else if (rd_fire) begin
                rd_cnt  <= rd_cnt + CW'(1);
            end
            // FIFO read latency is one cycle, so the valid/select/done flags trail rd_en.
            out_valid  <= rd_fire;
            out_sel    <= rd_fire & rd_next;
            frame_done <= rd_last;
            if (err_set)
                err <= 1'b1;
        end
    end

    assign bank_busy = {bank_st[1] != FREE, bank_st[0] != FREE};

endmodule
`default_nettype wire
